noc_local_injector: RTL and testbench
=====================================

Name: noc_local_injector

Overview:
- Network-interface packet injector that drives one router LOCAL input port of the mesh: tx, data_out flit and credit_i map to rxLocal[i], data_inLocal_flit[i] and credit_oLocal[i].
- Accepts a packet descriptor (target XY address, payload length) plus a payload flit stream from the local core.
- Serialises them into Hermes-format packets (header flit, size flit, payload flits) under credit-based flow control, at up to one flit per cycle.

Parameters:
- TAM_FLIT, 16, flit width in bits; the X and Y fields are TAM_FLIT/2 bits each.
- ADDRESS, 0, this node's {X,Y} address; reported on src_addr only, not inserted in the packet.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  descriptor valid.
- req_ready  out  1  descriptor accepted when req_valid && req_ready.
- req_target  in  TAM_FLIT  destination {X[TAM_FLIT-1:TAM_FLIT/2], Y[TAM_FLIT/2-1:0]}.
- req_size  in  TAM_FLIT  payload flit count, 0 allowed.
- pay_valid  in  1  payload flit valid.
- pay_ready  out  1  payload flit accepted when pay_valid && pay_ready.
- pay_data  in  TAM_FLIT  payload flit.
- credit_i  in  1  router LOCAL credit; 1 = router accepts a flit this cycle.
- tx  out  1  flit valid toward router.
- data_out  out  TAM_FLIT  flit toward router.
- busy  out  1  packet in progress or output register occupied.
- pkt_done  out  1  one-cycle pulse when the last flit of a packet is consumed by the router.
- src_addr  out  TAM_FLIT  constant ADDRESS.

Behaviour:
- Transfer rule: a flit is consumed on a rising edge with tx=1 and credit_i=1. While tx=1 and credit_i=0, data_out must hold stable.
- Output register (tx, data_out) is registered. Define "slot free" as (!tx || credit_i).
  - A new flit is loaded only when the slot is free, giving 1 flit/cycle with credit_i held at 1.
  - If the slot is free and no flit is loaded, tx clears.
- FSM states: IDLE, SIZE, PAYLOAD.
  - IDLE: req_ready = slot free. On accept: data_out <= req_target, tx <= 1, rem <= req_size; go to SIZE.
  - SIZE: when slot free, load req_size (latched). If rem==0, go to IDLE and mark this flit "last"; else go to PAYLOAD.
  - PAYLOAD: pay_ready = slot free (combinational from credit_i). On accept: load pay_data, rem <= rem-1. When rem==1 on accept, mark "last" and go to IDLE.
  - pay_ready = 0 in all other states; req_ready = 0 outside IDLE.
- pkt_done pulses on the cycle after the "last" flit is consumed.
- Minimum packet latency: descriptor accepted at edge N → header on the wire from N+1 → size flit from N+2 (credit held at 1).
- Back-to-back packets: a new descriptor can be accepted in the same cycle the last payload flit is being consumed. No bubble is inserted.
- pay_valid arriving while the FSM is not in PAYLOAD is ignored (not accepted).
- credit_i low for many cycles: state and rem frozen, all input handshakes stall.
- busy = (state != IDLE) || tx.
- Reset (including mid-packet): state=IDLE, tx=0, data_out=0, rem=0, pkt_done=0, busy=0. A partial packet is abandoned; the router shares the same reset.

Optional Feature:
- Macro: NOC_INJ_SEQNUM_EN.
- When defined:
  - Adds state SEQ between SIZE and PAYLOAD.
  - A TAM_FLIT-bit sequence counter (reset 0) is sent as the first flit after the size flit, then increments modulo 2^TAM_FLIT per packet.
  - The size flit carries req_size+1.
  - req_size must be ≤ 2^TAM_FLIT-2; larger values are illegal.
  - With req_size=0, SEQ is the last flit.
- When undefined: no SEQ state, no counter, and the size flit equals req_size.

Test Plan:
- Reset, then idle → tx=0, data_out=0, req_ready=1, busy=0, pkt_done=0.
- credit_i=1; descriptor target=16'h0102, size=3; payload AAAA, BBBB, CCCC streamed → wire flits 0102, 0003, AAAA, BBBB, CCCC on 5 consecutive cycles; pkt_done one cycle after CCCC.
- Size=0, target=16'h0201 → exactly 2 flits (0201, 0000); pay_ready never asserted; pkt_done after the size flit.
- Drop credit_i to 0 for 4 cycles while the header is on the wire → data_out stays 0102, req_ready=0 and pay_ready=0 throughout; sequence resumes unchanged when credit returns.
- Two back-to-back descriptors (size=1 each) with credit_i=1 → 6 flits with no idle cycle between packets; 2 pkt_done pulses.
- Assert reset while in PAYLOAD with 2 flits remaining → next cycle tx=0, busy=0, req_ready=1.
- With NOC_INJ_SEQNUM_EN: two size=1 packets → size flits 0002, 0002; seq flits 0000, then 0001.

Source files
------------

// File: rtl/noc_local_injector_if.sv
// Local-port bundle between the core-side injector and the router LOCAL input.
// slave = injector side, master = core/router side.
interface noc_local_injector_if #(
    parameter int TAM_FLIT = 16
);
    logic                req_valid;
    logic                req_ready;
    logic [TAM_FLIT-1:0] req_target;
    logic [TAM_FLIT-1:0] req_size;
    logic                pay_valid;
    logic                pay_ready;
    logic [TAM_FLIT-1:0] pay_data;
    logic                credit_i;
    logic                tx;
    logic [TAM_FLIT-1:0] data_out;
    logic                busy;
    logic                pkt_done;

    modport slave (
        input  req_valid, req_target, req_size,
        input  pay_valid, pay_data, credit_i,
        output req_ready, pay_ready, tx, data_out,
        output busy, pkt_done
    );

    modport master (
        output req_valid, req_target, req_size,
        output pay_valid, pay_data, credit_i,
        input  req_ready, pay_ready, tx, data_out,
        input  busy, pkt_done
    );
endinterface

// File: rtl/noc_local_injector.sv
// Hermes packet injector for a router LOCAL port (header, size, payload).
// NOC_INJ_SEQNUM_EN adds a per-packet sequence flit after the size flit.
module noc_local_injector #(
    parameter int                     TAM_FLIT = 16,
    parameter logic [TAM_FLIT-1:0]    ADDRESS  = '0
) (
    input  logic                clock,
    input  logic                reset,
    noc_local_injector_if.slave bus,
    output logic [TAM_FLIT-1:0] src_addr
);

`ifdef NOC_INJ_SEQNUM_EN
    typedef enum logic [1:0] {
        IDLE, SIZE, SEQ, PAYLOAD
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE, SIZE, PAYLOAD
    } state_t;
`endif

    localparam logic [TAM_FLIT-1:0] ONE = TAM_FLIT'(1);

    state_t              state_q, state_d;
    logic [TAM_FLIT-1:0] rem_q, rem_d;
    logic [TAM_FLIT-1:0] size_q, size_d;
    logic                tx_q, tx_d;
    logic [TAM_FLIT-1:0] data_q, data_d;
    logic                last_q, last_d;
    logic                done_q, done_d;
    logic                req_rdy, pay_rdy;
    logic                slot_free;
`ifdef NOC_INJ_SEQNUM_EN
    logic [TAM_FLIT-1:0] seq_q, seq_d;
`endif

    assign slot_free = !tx_q || bus.credit_i;
    assign done_d    = tx_q && bus.credit_i && last_q;

    // Next-state, flit selection and handshakes
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        size_d  = size_q;
        tx_d    = tx_q;
        data_d  = data_q;
        last_d  = last_q;
        req_rdy = 1'b0;
        pay_rdy = 1'b0;
`ifdef NOC_INJ_SEQNUM_EN
        seq_d   = seq_q;
`endif
        if (slot_free) begin
            tx_d   = 1'b0;
            last_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                req_rdy = slot_free;
                if (bus.req_valid && slot_free) begin
                    data_d  = bus.req_target;
                    tx_d    = 1'b1;
                    rem_d   = bus.req_size;
                    size_d  = bus.req_size;
                    state_d = SIZE;
                end
            end
            SIZE: begin
                if (slot_free) begin
                    tx_d = 1'b1;
`ifdef NOC_INJ_SEQNUM_EN
                    data_d  = size_q + ONE;
                    state_d = SEQ;
`else
                    data_d = size_q;
                    if (rem_q == '0) begin
                        last_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = PAYLOAD;
                    end
`endif
                end
            end
`ifdef NOC_INJ_SEQNUM_EN
            SEQ: begin
                if (slot_free) begin
                    tx_d   = 1'b1;
                    data_d = seq_q;
                    seq_d  = seq_q + ONE;
                    if (rem_q == '0) begin
                        last_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
`endif
            PAYLOAD: begin
                pay_rdy = slot_free;
                if (bus.pay_valid && slot_free) begin
                    tx_d   = 1'b1;
                    data_d = bus.pay_data;
                    rem_d  = rem_q - ONE;
                    if (rem_q == ONE) begin
                        last_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output register update
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            size_q  <= '0;
            tx_q    <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef NOC_INJ_SEQNUM_EN
            seq_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            size_q  <= size_d;
            tx_q    <= tx_d;
            data_q  <= data_d;
            last_q  <= last_d;
            done_q  <= done_d;
`ifdef NOC_INJ_SEQNUM_EN
            seq_q   <= seq_d;
`endif
        end
    end

    assign bus.req_ready = req_rdy;
    assign bus.pay_ready = pay_rdy;
    assign bus.tx        = tx_q;
    assign bus.data_out  = data_q;
    assign bus.pkt_done  = done_q;
    assign bus.busy      = (state_q != IDLE) || tx_q;
    assign src_addr      = ADDRESS;

endmodule

// File: tb/tb_noc_local_injector.sv
// Bench for noc_local_injector: flit-list reference model plus directed
// and randomized traffic; honours NOC_INJ_SEQNUM_EN like the design.
module tb_noc_local_injector;
    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] src_addr;

    noc_local_injector_if #(.TAM_FLIT(W)) bus ();

    noc_local_injector #(
        .TAM_FLIT(W),
        .ADDRESS (16'h0305)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .src_addr(src_addr)
    );

    always #5 clock = ~clock;

    // expected wire flits of all accepted packets, in order
    logic [W-1:0] exp_data[$];
    bit           exp_last[$];
    bit           exp_pay[$];
    // pending descriptors and their payloads, payloads owed to the DUT
    logic [W-1:0] d_tgt[$];
    logic [W-1:0] d_size[$];
    logic [W-1:0] pay_src[$];
    logic [W-1:0] feed[$];
    int           ldd;
    int           cons;
    int           total;
    bit           done_exp;
    logic [W-1:0] seq_m;
    int           done_cnt;
    int           n_cmp;
    int           n_err;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        exp_data.delete();
        exp_last.delete();
        exp_pay.delete();
        d_tgt.delete();
        d_size.delete();
        pay_src.delete();
        feed.delete();
        ldd      = 0;
        cons     = 0;
        total    = 0;
        done_exp = 1'b0;
        seq_m    = '0;
    endfunction

    function automatic void add_pkt(input logic [W-1:0] tgt,
                                    input int sz, input bit rnd);
        d_tgt.push_back(tgt);
        d_size.push_back(W'(sz));
        if (rnd)
            for (int i = 0; i < sz; i++)
                pay_src.push_back(W'($urandom));
    endfunction

    function automatic void push_flit(input logic [W-1:0] d,
                                      input bit l, input bit p);
        exp_data.push_back(d);
        exp_last.push_back(l);
        exp_pay.push_back(p);
    endfunction

    // one clock: drive, check against model, advance model at the edge
    task automatic cycle(input bit cr, input bit pv, input bit rv);
        bit           tx_e, slot, idle, rf, pf;
        logic [W-1:0] sz, tg, p;
        bus.credit_i  = cr;
        bus.req_valid = rv && (d_tgt.size() > 0);
        if (d_tgt.size() > 0) begin
            bus.req_target = d_tgt[0];
            bus.req_size   = d_size[0];
        end else begin
            bus.req_target = W'($urandom);
            bus.req_size   = W'($urandom);
        end
        bus.pay_valid = pv;
        if (feed.size() > 0) bus.pay_data = feed[0];
        else bus.pay_data = 16'hDEAD;
        #1;
        tx_e = ldd > cons;
        slot = !tx_e || cr;
        idle = (ldd == total);
        chk("tx", bus.tx, tx_e);
        if (tx_e) chk("data_out", bus.data_out, exp_data[cons]);
        chk("pkt_done", bus.pkt_done, done_exp);
        chk("busy", bus.busy, tx_e || !idle);
        chk("req_ready", bus.req_ready, idle && slot);
        chk("pay_ready", bus.pay_ready,
            !idle && exp_pay[ldd] && slot);
        if (bus.pkt_done) done_cnt++;
        rf = bus.req_valid && bus.req_ready;
        pf = bus.pay_valid && bus.pay_ready && (feed.size() > 0);
        @(posedge clock);
        if (rf) begin
            tg = d_tgt.pop_front();
            sz = d_size.pop_front();
            push_flit(tg, 1'b0, 1'b0);
`ifdef NOC_INJ_SEQNUM_EN
            push_flit(sz + W'(1), 1'b0, 1'b0);
            push_flit(seq_m, sz == 0, 1'b0);
            seq_m = seq_m + W'(1);
`else
            push_flit(sz, sz == 0, 1'b0);
`endif
            for (int i = 0; i < int'(sz); i++) begin
                p = pay_src.pop_front();
                feed.push_back(p);
                push_flit(p, i == int'(sz) - 1, 1'b1);
            end
            total = exp_data.size();
        end
        if (pf) void'(feed.pop_front());
        done_exp = tx_e && cr && exp_last[cons];
        if (tx_e && cr) cons++;
        if (slot && ldd < total && (!exp_pay[ldd] || pf)) ldd++;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.pay_valid = 1'b0;
        bus.credit_i  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        #1;
    endtask

    initial begin
        int c0;
        n_cmp    = 0;
        n_err    = 0;
        done_cnt = 0;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_target = '0;
        bus.req_size   = '0;
        bus.pay_valid  = 1'b0;
        bus.pay_data   = '0;
        bus.credit_i   = 1'b0;
        @(negedge clock);
        @(negedge clock);
        do_reset();
        chk("rst_tx", bus.tx, 0);
        chk("rst_data", bus.data_out, 0);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_pkt_done", bus.pkt_done, 0);
        chk("src_addr", src_addr, 16'h0305);
        @(negedge clock);

        // basic 3-flit payload
        add_pkt(16'h0102, 3, 1'b0);
        pay_src.push_back(16'hAAAA);
        pay_src.push_back(16'hBBBB);
        pay_src.push_back(16'hCCCC);
        c0 = done_cnt;
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 1'b1);
        chk("basic_done_cnt", done_cnt - c0, 1);

        // empty payload, stray pay_valid must be ignored
        add_pkt(16'h0201, 0, 1'b0);
        c0 = done_cnt;
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1);
        chk("size0_done_cnt", done_cnt - c0, 1);

        // credit stall with header on the wire
        add_pkt(16'h0102, 2, 1'b1);
        add_pkt(16'h0303, 1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1);
        chk("stall_hold", bus.data_out, 16'h0102);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b1);

        // back-to-back size-1 packets
        add_pkt(16'h0111, 1, 1'b1);
        add_pkt(16'h0222, 1, 1'b1);
        c0 = done_cnt;
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b1);
        chk("b2b_done_cnt", done_cnt - c0, 2);

        // reset while in PAYLOAD with 2 flits remaining
        add_pkt(16'h0404, 4, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1);
        chk("pre_rst_busy", bus.busy, 1);
        do_reset();
        chk("mid_rst_tx", bus.tx, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_req_ready", bus.req_ready, 1);
        chk("mid_rst_pkt_done", bus.pkt_done, 0);
        @(negedge clock);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if (d_tgt.size() < 2)
                add_pkt(W'($urandom), $urandom_range(0, 4), 1'b1);
            cycle($urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1);
        end

        // bounded drain
        for (int i = 0; i < 500; i++) begin
            if (d_tgt.size() == 0 && cons == total && !done_exp) break;
            cycle(1'b1, 1'b1, 1'b1);
        end
        chk("drain", (d_tgt.size() == 0) && (cons == total), 1);
        cycle(1'b1, 1'b1, 1'b1);
        chk("final_busy", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
